// File: rtl/output_buffer_if.sv
// Output buffer bundle: PE-array capture inputs, serial beat stream and status flags.
interface output_buffer_if #(
    parameter int N_DIM_ARRAY     = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int N_DIM_ARRAY_LOG = $clog2(N_DIM_ARRAY)
);
    logic [2:0]                             mode;
    logic                                   load;
    logic [N_DIM_ARRAY-1:0][DATA_WIDTH-1:0] parallel_input_array;
    logic [N_DIM_ARRAY_LOG:0]               drain_width;
    logic                                   out_ready;
    logic                                   out_valid;
    logic [N_DIM_ARRAY-1:0][DATA_WIDTH-1:0] serial_output;
    logic [N_DIM_ARRAY_LOG:0]               serial_count;
    logic                                   busy;
    logic                                   done;
    logic                                   overflow;

    modport slave (
        input  mode, load, parallel_input_array, drain_width, out_ready,
        output out_valid, serial_output, serial_count, busy, done, overflow
    );

    modport master (
        output mode, load, parallel_input_array, drain_width, out_ready,
        input  out_valid, serial_output, serial_count, busy, done, overflow
    );
endinterface

// File: rtl/output_buffer.sv
// Captures a PE-array result vector and drains it as variable-width beats, lane 0 first.
// Define OUTPUT_BUFFER_RELU_EN to clamp negative elements to 0 at capture in CNN/FC modes.
module output_buffer #(
    parameter int         N_DIM_ARRAY     = 8,
    parameter int         DATA_WIDTH      = 8,
    parameter int         N_DIM_ARRAY_LOG = $clog2(N_DIM_ARRAY),
    parameter logic [2:0] MODE_CNN        = 3'd0,
    parameter logic [2:0] MODE_FC         = 3'd1,
    parameter logic [2:0] MODE_EWS        = 3'd2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    output_buffer_if.slave bus
);
    localparam int CW = N_DIM_ARRAY_LOG + 1;
    localparam logic [CW-1:0] NLanes = CW'(N_DIM_ARRAY);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;
    typedef logic [N_DIM_ARRAY-1:0][DATA_WIDTH-1:0] vec_t;

    state_e        state_q, state_d;
    vec_t          buf_q, buf_d;
    logic [CW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] width_q, width_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] remain, count, eff_width, idx;
    logic          handshake, final_beat, accept;
    vec_t          capture;

    // Only CNN honours drain_width; FC/EWS always drain the whole vector in one beat.
    always_comb begin
        eff_width = NLanes;
        case (bus.mode)
            MODE_CNN: begin
                if (bus.drain_width == '0) begin
                    eff_width = CW'(1);
                end else if (bus.drain_width > NLanes) begin
                    eff_width = NLanes;
                end else begin
                    eff_width = bus.drain_width;
                end
            end
            MODE_FC, MODE_EWS: eff_width = NLanes;
            default:           eff_width = NLanes;
        endcase
    end

    always_comb begin
        capture = bus.parallel_input_array;
`ifdef OUTPUT_BUFFER_RELU_EN
        if (bus.mode == MODE_CNN || bus.mode == MODE_FC) begin
            for (int i = 0; i < N_DIM_ARRAY; i++) begin
                if (capture[i][DATA_WIDTH-1]) capture[i] = '0;
            end
        end
`endif
    end

    assign remain     = NLanes - ptr_q;
    assign count      = (width_q < remain) ? width_q : remain;
    assign handshake  = (state_q == StDrain) && bus.out_ready;
    assign final_beat = handshake && ((ptr_q + count) == NLanes);
    assign accept     = bus.load && ((state_q == StIdle) || final_beat);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        ptr_d   = ptr_q;
        width_d = width_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = StIdle;
            buf_d   = '0;
            ptr_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (accept) begin
                state_d = StDrain;
                buf_d   = capture;
                ptr_d   = '0;
                width_d = eff_width;
            end else if (final_beat) begin
                state_d = StIdle;
                ptr_d   = '0;
            end else if (handshake) begin
                ptr_d = ptr_q + count;
            end
            if (bus.load && !accept) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            buf_q   <= '0;
            ptr_q   <= '0;
            width_q <= CW'(1);
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            ptr_q   <= ptr_d;
            width_q <= width_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        bus.out_valid     = 1'b0;
        bus.busy          = 1'b0;
        bus.done          = 1'b0;
        bus.serial_count  = '0;
        bus.serial_output = '0;
        idx               = '0;
        if (state_q == StDrain) begin
            bus.out_valid    = 1'b1;
            bus.busy         = 1'b1;
            bus.serial_count = count;
            // A flush in the same cycle swallows the final handshake.
            bus.done         = final_beat && !clear;
            for (int j = 0; j < N_DIM_ARRAY; j++) begin
                idx = ptr_q + CW'(j);
                if (CW'(j) < count) begin
                    bus.serial_output[j] = buf_q[idx[N_DIM_ARRAY_LOG-1:0]];
                end
            end
        end
    end

    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_output_buffer.sv
// Directed self-checking bench for output_buffer; expected beats are hand-derived per scenario.
module tb_output_buffer;
    localparam int N   = 8;
    localparam int DW  = 8;
    localparam int LOG = 3;
    localparam int CW  = LOG + 1;
    localparam logic [2:0] MODE_CNN = 3'd0;
    localparam logic [2:0] MODE_FC  = 3'd1;
    localparam logic [2:0] MODE_EWS = 3'd2;

    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef logic [CW-1:0] cnt_t;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    int   n_checks = 0;
    int   n_pass   = 0;

    output_buffer_if #(.N_DIM_ARRAY(N), .DATA_WIDTH(DW)) bus ();

    output_buffer #(.N_DIM_ARRAY(N), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector whose first cnt lanes hold base, base+1, ...; remaining lanes zero.
    function automatic vec_t lanes(input int base, input int cnt);
        lanes = '0;
        for (int j = 0; j < cnt; j++) lanes[j] = DW'(base + j);
    endfunction

    task automatic do_load(input logic [2:0] m, input cnt_t dw, input vec_t d);
        bus.mode                 = m;
        bus.drain_width          = dw;
        bus.parallel_input_array = d;
        bus.load                 = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear = 1'b0;
        bus.load = 1'b0;
        bus.out_ready = 1'b0;
        bus.mode = MODE_CNN;
        bus.drain_width = '0;
        bus.parallel_input_array = '0;
        #1 reset = 1'b0;
        repeat (2) tick();
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", bus.overflow); else n_pass++;
        n_checks++; if (bus.serial_count !== cnt_t'(0)) $display("FAIL reset_count got %0d want 0", bus.serial_count); else n_pass++;
        n_checks++; if (bus.serial_output !== vec_t'(0)) $display("FAIL reset_data got %h want 0", bus.serial_output); else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_cnn_drain();
        int bases[3] = '{0, 3, 6};
        int cnts[3]  = '{3, 3, 2};
        bus.out_ready = 1'b1;
        do_load(MODE_CNN, cnt_t'(3), lanes(0, N));
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.serial_count !== cnt_t'(cnts[k]) ||
                bus.serial_output !== lanes(bases[k], cnts[k]) || bus.done !== (k == 2))
                $display("FAIL cnn_beat%0d got v=%b c=%0d d=%h done=%b want v=1 c=%0d d=%h done=%b",
                         k, bus.out_valid, bus.serial_count, bus.serial_output, bus.done,
                         cnts[k], lanes(bases[k], cnts[k]), (k == 2));
            else n_pass++;
            tick();
        end
        n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL cnn_after got busy=%b v=%b done=%b want 0 0 0", bus.busy, bus.out_valid, bus.done);
        else n_pass++;
    endtask

    task automatic test_full_width();
        bus.out_ready = 1'b1;
        do_load(MODE_FC, cnt_t'(2), lanes(10, N));
        n_checks++; if (bus.serial_count !== cnt_t'(8) || bus.serial_output !== lanes(10, 8) || bus.done !== 1'b1)
            $display("FAIL fc_beat got c=%0d d=%h done=%b want c=8 d=%h done=1",
                     bus.serial_count, bus.serial_output, bus.done, lanes(10, 8));
        else n_pass++;
        tick();
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL fc_after busy got %b want 0", bus.busy); else n_pass++;
        do_load(MODE_EWS, cnt_t'(1), lanes(30, N));
        n_checks++; if (bus.serial_count !== cnt_t'(8) || bus.serial_output !== lanes(30, 8))
            $display("FAIL ews_beat got c=%0d d=%h want c=8 d=%h", bus.serial_count, bus.serial_output, lanes(30, 8));
        else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        do_load(MODE_CNN, cnt_t'(4), lanes(0, N));
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.serial_count !== cnt_t'(4) ||
                bus.serial_output !== lanes(0, 4) || bus.done !== 1'b0)
                $display("FAIL stall_hold%0d got v=%b c=%0d d=%h done=%b want v=1 c=4 d=%h done=0",
                         c, bus.out_valid, bus.serial_count, bus.serial_output, bus.done, lanes(0, 4));
            else n_pass++;
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL stall_first_done got %b want 0", bus.done); else n_pass++;
        tick();
        n_checks++; if (bus.serial_count !== cnt_t'(4) || bus.serial_output !== lanes(4, 4) || bus.done !== 1'b1)
            $display("FAIL stall_second got c=%0d d=%h done=%b want c=4 d=%h done=1",
                     bus.serial_count, bus.serial_output, bus.done, lanes(4, 4));
        else n_pass++;
        tick();
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL stall_after busy got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        do_load(MODE_CNN, cnt_t'(8), lanes(20, N));
        n_checks++; if (bus.serial_output !== lanes(20, 8)) $display("FAIL b2b_a got %h want %h", bus.serial_output, lanes(20, 8)); else n_pass++;
        bus.out_ready = 1'b1;
        bus.parallel_input_array = lanes(40, N);
        bus.load = 1'b1;
        #1;
        n_checks++; if (bus.done !== 1'b1) $display("FAIL b2b_done_a got %b want 1", bus.done); else n_pass++;
        tick();
        bus.load = 1'b0;
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.serial_output !== lanes(40, 8) || bus.overflow !== 1'b0)
            $display("FAIL b2b_b got v=%b d=%h ovf=%b want v=1 d=%h ovf=0",
                     bus.out_valid, bus.serial_output, bus.overflow, lanes(40, 8));
        else n_pass++;
        bus.parallel_input_array = lanes(60, N);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        n_checks++; if (bus.overflow !== 1'b1 || bus.serial_output !== lanes(40, 8))
            $display("FAIL b2b_c got ovf=%b d=%h want ovf=1 d=%h", bus.overflow, bus.serial_output, lanes(40, 8));
        else n_pass++;
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.done !== 1'b1) $display("FAIL b2b_done_b got %b want 1", bus.done); else n_pass++;
        tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.overflow !== 1'b1)
            $display("FAIL b2b_after got busy=%b ovf=%b want 0 1", bus.busy, bus.overflow);
        else n_pass++;
    endtask

    task automatic test_width_clamp();
        bus.out_ready = 1'b1;
        do_load(MODE_CNN, cnt_t'(0), lanes(50, N));
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (bus.serial_count !== cnt_t'(1) || bus.serial_output !== lanes(50 + k, 1) || bus.done !== (k == 7))
                $display("FAIL w0_beat%0d got c=%0d d=%h done=%b want c=1 d=%h done=%b",
                         k, bus.serial_count, bus.serial_output, bus.done, lanes(50 + k, 1), (k == 7));
            else n_pass++;
            tick();
        end
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL w0_after busy got %b want 0", bus.busy); else n_pass++;
        do_load(MODE_CNN, cnt_t'(15), lanes(70, N));
        n_checks++; if (bus.serial_count !== cnt_t'(8) || bus.serial_output !== lanes(70, 8) || bus.done !== 1'b1)
            $display("FAIL w15_beat got c=%0d d=%h done=%b want c=8 d=%h done=1",
                     bus.serial_count, bus.serial_output, bus.done, lanes(70, 8));
        else n_pass++;
        tick();
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL w15_after busy got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_clear();
        bus.out_ready = 1'b0;
        do_load(MODE_CNN, cnt_t'(8), lanes(0, N));
        n_checks++; if (bus.overflow !== 1'b1) $display("FAIL clr_pre_ovf got %b want 1", bus.overflow); else n_pass++;
        clear = 1'b1;
        bus.out_ready = 1'b1;
        bus.load = 1'b1;
        #1;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL clr_done got %b want 0", bus.done); else n_pass++;
        tick();
        clear = 1'b0;
        bus.load = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.serial_count !== cnt_t'(0) || bus.serial_output !== vec_t'(0))
            $display("FAIL clr_after got v=%b busy=%b ovf=%b c=%0d d=%h want all 0",
                     bus.out_valid, bus.busy, bus.overflow, bus.serial_count, bus.serial_output);
        else n_pass++;
        tick();
        n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL clr_later got done=%b busy=%b want 0 0", bus.done, bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        do_load(MODE_CNN, cnt_t'(8), lanes(80, N));
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        n_checks++; if (bus.busy !== 1'b1 || bus.overflow !== 1'b1)
            $display("FAIL rst_pre got busy=%b ovf=%b want 1 1", bus.busy, bus.overflow);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0 || bus.serial_count !== cnt_t'(0))
            $display("FAIL rst_async got v=%b busy=%b ovf=%b c=%0d want all 0",
                     bus.out_valid, bus.busy, bus.overflow, bus.serial_count);
        else n_pass++;
        tick();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL rst_after got done=%b v=%b want 0 0", bus.done, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_relu();
        vec_t d;
        vec_t exp_cnn;
        d = lanes(0, N);
        d[0] = 8'hFD;
        d[1] = 8'd5;
        exp_cnn = d;
`ifdef OUTPUT_BUFFER_RELU_EN
        exp_cnn[0] = '0;
`endif
        bus.out_ready = 1'b0;
        do_load(MODE_CNN, cnt_t'(8), d);
        n_checks++; if (bus.serial_output !== exp_cnn)
            $display("FAIL relu_cnn got %h want %h", bus.serial_output, exp_cnn);
        else n_pass++;
        bus.out_ready = 1'b1;
        tick();
        do_load(MODE_EWS, cnt_t'(8), d);
        n_checks++; if (bus.serial_output !== d)
            $display("FAIL relu_ews got %h want %h", bus.serial_output, d);
        else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_cnn_drain();
        test_full_width();
        test_stall();
        test_back_to_back();
        test_width_clamp();
        test_clear();
        test_reset_mid();
        test_relu();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 SHALL have parameter N_DIM_ARRAY, default 8, number of PE-array lanes (power of two, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, signed element width.
REQ-003 SHALL have parameter N_DIM_ARRAY_LOG, default $clog2(N_DIM_ARRAY).
REQ-004 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have clear  input  1  synchronous flush, highest non-reset priority.
REQ-007 SHALL have mode  input  3  MODE_CNN / MODE_FC / MODE_EWS encoding from the parameters package.
REQ-008 SHALL have load  input  1  capture parallel_input_array this cycle.
REQ-009 SHALL have parallel_input_array  input  N_DIM_ARRAY x DATA_WIDTH signed  PE-array results.
REQ-010 SHALL have drain_width  input  N_DIM_ARRAY_LOG+1  elements per output beat, sampled on accepted load.
REQ-011 SHALL have out_ready  input  1  downstream accepts beat.
REQ-012 SHALL have out_valid  output  1  beat present on serial_output.
REQ-013 SHALL have serial_output  output  N_DIM_ARRAY x DATA_WIDTH signed  beat data, lane 0 first.
REQ-014 SHALL have serial_count  output  N_DIM_ARRAY_LOG+1  valid lanes in current beat.
REQ-015 SHALL have busy  output  1  high in DRAIN state.
REQ-016 SHALL have done  output  1  one-cycle pulse on final accepted beat.
REQ-017 SHALL have overflow  output  1  sticky: load arrived while busy and not on final beat.

Function
REQ-018 SHALL implement FSM IDLE/DRAIN; IDLE -> DRAIN on load; DRAIN -> IDLE on final handshake without load.
REQ-019 SHALL, on accepted load, register array into buffer, set read pointer 0, latch effective width W; out_valid rises the following cycle (1-cycle latency).
REQ-020 SHALL set W = drain_width clamped to [1, N_DIM_ARRAY] in MODE_CNN; W = N_DIM_ARRAY in MODE_FC and MODE_EWS regardless of drain_width.
REQ-021 SHALL in DRAIN drive serial_count = min(W, N_DIM_ARRAY - ptr), serial_output[j] = buffer[ptr+j] for j < serial_count, else 0.
REQ-022 SHALL hold out_valid, serial_output and serial_count stable while out_valid && !out_ready.
REQ-023 SHALL on handshake (out_valid && out_ready) advance ptr by serial_count; handshake with ptr+serial_count == N_DIM_ARRAY is final.
REQ-024 SHALL accept load in IDLE, or in DRAIN in the same cycle as the final handshake (back-to-back: done pulses, new capture, stays DRAIN).
REQ-025 SHALL ignore load in DRAIN otherwise, leaving buffer/ptr unchanged and setting overflow.
REQ-026 SHALL, on clear, zero buffer, ptr, overflow, go IDLE, deassert out_valid/done next cycle; clear overrides a simultaneous load or handshake.
REQ-027 SHALL keep out_valid, serial_output, serial_count at 0 in IDLE.

Reset
REQ-028 SHALL on reset low immediately set state IDLE, buffer 0, ptr 0, W = 1, out_valid 0, serial_output 0, serial_count 0, busy 0, done 0, overflow 0.
REQ-029 SHALL abandon an in-progress drain on reset with no done pulse after release.

Configuration
REQ-030 SHALL, with OUTPUT_BUFFER_RELU_EN defined, clamp each negative element to 0 at capture in MODE_CNN and MODE_FC (MODE_EWS unclamped).
REQ-031 SHALL, without OUTPUT_BUFFER_RELU_EN, capture all elements unmodified in every mode.

Verification
REQ-032 SHALL cover: MODE_CNN, drain_width=3, load {0..7}, out_ready=1 -> beats {0,1,2}/3, {3,4,5}/3, {6,7}/2, done on third beat, busy low after.
REQ-033 SHALL cover: MODE_FC, drain_width=2, load {10..17} -> single beat count 8 with {10..17}, done same cycle as handshake.
REQ-034 SHALL cover: drain_width=4, out_ready low 5 cycles after first valid -> beat {0..3} held stable 5 cycles, then ptr advances to 4.
REQ-035 SHALL cover: drain_width=8, load A, then load B on final handshake cycle -> done pulse, next beat equals B, no overflow; load C mid-drain of B -> overflow=1, B drained intact.
REQ-036 SHALL cover: drain_width=0 and drain_width=15 -> W=1 (8 beats) and W=8 (1 beat) respectively.
REQ-037 SHALL cover: clear and reset asserted mid-drain -> out_valid 0, overflow 0, busy 0, no done; with OUTPUT_BUFFER_RELU_EN, load {-3,5,...} in MODE_CNN -> first beat lane 0 = 0.
